vhm_fetch_sequencer: RTL and testbench

Instruction-sequencing controller for the RV64IM virtual hardware machine (VHM). It owns the program counter, fetches 32-bit instructions from a request/grant/valid memory read port and presents each one to the VHM for a single execute clock. It then checks the VHM's invalid-instruction flag, advances or redirects the PC, and halts with a recorded cause on error, EBREAK or fetch timeout.

---
 rtl/vhm_fetch_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vhm_fetch_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vhm_fetch_sequencer.sv
// vhm_fetch_sequencer
//
// Instruction-sequencing controller for the RV64IM virtual hardware machine.
// Owns the program counter and fetches one 32-bit instruction at a time over
// a request/grant/valid read port. Each instruction is presented to the VHM
// for a single execute clock. The sequencer then checks the VHM's
// invalid-instruction flag and either advances/redirects the PC or halts
// with a recorded cause.
//
// Optional feature macro: VHM_SEQ_STEP_EN
//   When defined, adds the step_en/step inputs and a PAUSE state used for
//   single-stepping.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, clear      leave IDLE / leave HALT (clear also reloads RESET_PC)
//   mem_req/addr      fetch request and address (address always equals pc)
//   mem_gnt           request accepted
//   mem_rvalid/rdata  read data return
//   instr, exec_valid instruction and one-cycle execute strobe to the VHM
//   vhm_status        VHM invalid-instruction flag, sampled in CHECK
//   redirect_valid/pc taken branch/jump target, sampled in CHECK
//   pc, retired       program counter, retired-instruction count
//   halted, halt_cause
//                     0 none, 1 illegal, 2 misaligned redirect, 3 EBREAK,
//                     4 fetch timeout
//   step_en, step     (VHM_SEQ_STEP_EN only) single-step control

module vhm_fetch_sequencer #(
  parameter logic [63:0] RESET_PC      = 64'h0000_0000_8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        exec_valid,
  input  logic        vhm_status,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
`ifdef VHM_SEQ_STEP_EN
  input  logic        step_en,
  input  logic        step,
`endif
  output logic [63:0] pc,
  output logic [63:0] retired,
  output logic        halted,
  output logic [2:0]  halt_cause
);

  localparam logic [31:0] EBREAK_WORD  = 32'h0010_0073;
  localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_ILLEGAL  = 3'd1;
  localparam logic [2:0] CAUSE_MISALIGN = 3'd2;
  localparam logic [2:0] CAUSE_EBREAK   = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_ISSUE,
    S_CHECK,
    S_HALT
`ifdef VHM_SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] fetch_cnt;
  logic [2:0]  cause_next;
  logic        in_fetch;
  logic        timeout_hit;
  logic        rdata_accept;
  logic        redirect_bad;
  logic        check_ok;

  // The fetch counter holds the number of cycles already spent on this fetch,
  // so the last permitted cycle is the one where it equals FETCH_TIMEOUT-1.
  assign in_fetch     = (state == S_FETCH_REQ) || (state == S_FETCH_WAIT);
  assign timeout_hit  = in_fetch && (fetch_cnt == TIMEOUT_LAST);
  assign rdata_accept = (state == S_FETCH_WAIT) && mem_rvalid;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign check_ok     = (state == S_CHECK) && !vhm_status && !redirect_bad;
  assign mem_addr     = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; also selects the cause recorded on entry to HALT
  always_comb begin
    state_next = state;
    cause_next = CAUSE_NONE;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH_REQ;
      end
      S_FETCH_REQ: begin
        if (timeout_hit) begin
          state_next = S_HALT;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem_gnt) begin
          state_next = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        // Data arriving on the final allowed cycle still beats the timeout.
        if (mem_rvalid) begin
          if (mem_rdata == EBREAK_WORD) begin
            state_next = S_HALT;
            cause_next = CAUSE_EBREAK;
          end else begin
            state_next = S_ISSUE;
          end
        end else if (timeout_hit) begin
          state_next = S_HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_ISSUE: begin
        state_next = S_CHECK;
      end
      S_CHECK: begin
        if (vhm_status) begin
          state_next = S_HALT;
          cause_next = CAUSE_ILLEGAL;
        end else if (redirect_bad) begin
          state_next = S_HALT;
          cause_next = CAUSE_MISALIGN;
        end else begin
`ifdef VHM_SEQ_STEP_EN
          state_next = step_en ? S_PAUSE : S_FETCH_REQ;
`else
          state_next = S_FETCH_REQ;
`endif
        end
      end
      S_HALT: begin
        if (clear) state_next = S_IDLE;
      end
`ifdef VHM_SEQ_STEP_EN
      S_PAUSE: begin
        if (step || !step_en) state_next = S_FETCH_REQ;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    mem_req    = (state == S_FETCH_REQ);
    exec_valid = (state == S_ISSUE);
    halted     = (state == S_HALT);
  end

  // Datapath: PC, retire counter, instruction latch, halt cause, fetch timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      retired    <= 64'd0;
      instr      <= 32'd0;
      halt_cause <= CAUSE_NONE;
      fetch_cnt  <= 16'd0;
    end else begin
      if ((state_next == S_FETCH_REQ) && (state != S_FETCH_REQ)) begin
        fetch_cnt <= 16'd0;
      end else if (in_fetch) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end

      if (rdata_accept) begin
        instr <= mem_rdata;
      end

      if (check_ok) begin
        pc      <= redirect_valid ? redirect_pc : pc + 64'd4;
        retired <= retired + 64'd1;
      end

      if ((state != S_HALT) && (state_next == S_HALT)) begin
        halt_cause <= cause_next;
      end else if ((state == S_HALT) && clear) begin
        pc         <= RESET_PC;
        halt_cause <= CAUSE_NONE;
      end
    end
  end

endmodule

// File: tb/tb_vhm_fetch_sequencer.sv
// Testbench for vhm_fetch_sequencer (FETCH_TIMEOUT = 8).
// Stimulus is applied on the falling edge and outputs are sampled there too,
// so everything is observed half a cycle away from the active edge.
// A small architectural model (pc, retired count, last instruction, halt
// cause) predicts the sequencer's visible state after each instruction.
// Define VHM_SEQ_STEP_EN to also exercise single-stepping.

module tb_vhm_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        exec_valid;
  logic        vhm_status;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic [63:0] retired;
  logic        halted;
  logic [2:0]  halt_cause;
`ifdef VHM_SEQ_STEP_EN
  logic        step_en;
  logic        step;
`endif

  int total_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;
  int cyc         = 0;
  int issue_cyc   = 0;
  int start_cyc   = 0;

  // Reference model state
  logic [63:0] m_pc;
  logic [63:0] m_retired;
  logic [31:0] m_instr;
  logic        m_halted;
  logic [2:0]  m_cause;
  logic        expect_pause;

  // Random-loop scratch
  logic [31:0] r_word;
  logic [63:0] r_target;
  logic        r_status;
  logic        r_redir;
  int          r_gd;
  int          r_rd;
  int          r_sel;

  vhm_fetch_sequencer #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .clear          (clear),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .exec_valid     (exec_valid),
    .vhm_status     (vhm_status),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef VHM_SEQ_STEP_EN
    .step_en        (step_en),
    .step           (step),
`endif
    .pc             (pc),
    .retired        (retired),
    .halted         (halted),
    .halt_cause     (halt_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc      = RESET_PC;
    m_retired = 64'd0;
    m_instr   = 32'd0;
    m_halted  = 1'b0;
    m_cause   = 3'd0;
  endtask

  // Pulse start in IDLE; returns in the first FETCH_REQ cycle.
  task automatic doStart();
    start_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Pulse clear in HALT and confirm the return to IDLE.
  task automatic doClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pc     = RESET_PC;
    m_cause  = 3'd0;
    m_halted = 1'b0;
    checkOutput("clear_pc", pc, m_pc);
    checkOutput("clear_halted", halted, m_halted);
    checkOutput("clear_cause", halt_cause, m_cause);
    checkOutput("clear_req", mem_req, 1'b0);
    checkOutput("clear_retired", retired, m_retired);
  endtask

  // One instruction, entered in the first FETCH_REQ cycle. gd = grant delay,
  // rd = read-data delay after grant. Rvalid is also asserted (with junk) in
  // the grant cycle, which must not be taken as the instruction.
  task automatic applyStimulus(input logic [31:0] word, input int gd, input int rd,
                               input logic status, input logic redir,
                               input logic [63:0] rpc);
    checkOutput("req_high", mem_req, 1'b1);
    checkOutput("req_addr", mem_addr, m_pc);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      checkOutput("req_hold", mem_req, 1'b1);
      checkOutput("addr_hold", mem_addr, m_pc);
    end
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = ~word;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput("wait_req_low", mem_req, 1'b0);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      checkOutput("wait_no_exec", exec_valid, 1'b0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    m_instr    = word;
    if (word == EBREAK) begin
      m_halted = 1'b1;
      m_cause  = 3'd3;
      checkOutput("ebreak_no_exec", exec_valid, 1'b0);
      checkOutput("ebreak_halted", halted, m_halted);
      checkOutput("ebreak_cause", halt_cause, m_cause);
      checkOutput("ebreak_retired", retired, m_retired);
      checkOutput("ebreak_pc", pc, m_pc);
      return;
    end
    issue_cyc = cyc;
    checkOutput("exec_valid", exec_valid, 1'b1);
    checkOutput("instr", instr, m_instr);
    vhm_status     = status;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
    checkOutput("exec_one_cycle", exec_valid, 1'b0);
    checkOutput("instr_stable", instr, m_instr);
    checkOutput("pc_before_check", pc, m_pc);
    @(negedge clk);
    vhm_status     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = {$urandom(), $urandom()};
    if (status) begin
      m_halted = 1'b1;
      m_cause  = 3'd1;
    end else if (redir && (rpc[1:0] != 2'b00)) begin
      m_halted = 1'b1;
      m_cause  = 3'd2;
    end else begin
      m_pc      = redir ? rpc : m_pc + 64'd4;
      m_retired = m_retired + 64'd1;
    end
    checkOutput("pc_after", pc, m_pc);
    checkOutput("retired_after", retired, m_retired);
    checkOutput("halted_after", halted, m_halted);
    checkOutput("cause_after", halt_cause, m_cause);
    checkOutput("req_after", mem_req, !m_halted && !expect_pause);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    clear          = 1'b0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'h0;
    vhm_status     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    expect_pause   = 1'b0;
`ifdef VHM_SEQ_STEP_EN
    step_en        = 1'b0;
    step           = 1'b0;
`endif
    modelReset();

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_addr", mem_addr, RESET_PC);
    checkOutput("rst_retired", retired, 64'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_exec", exec_valid, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_cause", halt_cause, 3'd0);
    rst_n = 1'b1;

    // IDLE ignores everything but start
    clear      = 1'b1;
    mem_rvalid = 1'b1;
    mem_gnt    = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    checkOutput("idle_req", mem_req, 1'b0);
    checkOutput("idle_pc", pc, RESET_PC);

    // Straight-line fetch with minimum latency
    $display("[TB] straight-line fetch");
    doStart();
    applyStimulus(32'h0000_10B7, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("start_to_exec", 64'(issue_cyc - start_cyc), 64'd3);
    checkOutput("pc_plus4", pc, 64'h8000_0004);

    // Longest fetch that still fits inside the timeout window
    applyStimulus(32'h0020_8113, 3, 3, 1'b0, 1'b0, 64'h0);

    // Aligned redirect, then wrap-around of pc+4
    $display("[TB] redirect and wrap");
    applyStimulus(32'h0000_006F, 1, 0, 1'b0, 1'b1, 64'h8000_0100);
    applyStimulus(32'h0000_0013, 0, 2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(32'h0000_0013, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("pc_wrapped", pc, 64'h0);

    // Misaligned redirect halts with cause 2; start is ignored in HALT
    applyStimulus(32'h0000_006F, 0, 0, 1'b0, 1'b1, 64'h8000_0102);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("halt_ignores_start", halted, 1'b1);
    checkOutput("halt_req_low", mem_req, 1'b0);
    doClear();

    // Start and clear together in IDLE: start wins; then an illegal instruction
    $display("[TB] illegal instruction");
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    applyStimulus(32'hFFFF_FFFF, 0, 1, 1'b1, 1'b0, 64'h0);
    doClear();

    // EBREAK
    $display("[TB] ebreak");
    doStart();
    applyStimulus(EBREAK, 1, 1, 1'b0, 1'b0, 64'h0);
    doClear();

    // Fetch timeout with grant withheld, followed by a stray rvalid
    $display("[TB] fetch timeout");
    doStart();
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_req_high", mem_req, 1'b1);
      @(negedge clk);
    end
    checkOutput("to_halted", halted, 1'b1);
    checkOutput("to_cause", halt_cause, 3'd4);
    checkOutput("to_req_low", mem_req, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("stray_halted", halted, 1'b1);
    checkOutput("stray_cause", halt_cause, 3'd4);
    checkOutput("stray_instr", instr, m_instr);
    checkOutput("stray_exec", exec_valid, 1'b0);
    doClear();

    // Randomized run against the model; halts are cleared and restarted
    $display("[TB] random run");
    doStart();
    for (int n = 0; n < 40; n++) begin
      r_sel    = $urandom_range(0, 15);
      r_word   = $urandom();
      if (r_word == EBREAK) r_word = 32'h0000_0013;
      r_gd     = $urandom_range(0, 3);
      r_rd     = $urandom_range(0, 3);
      r_status = 1'b0;
      r_redir  = 1'b0;
      r_target = {$urandom(), $urandom()};
      r_target[1:0] = 2'b00;
      case (r_sel)
        0: r_status = 1'b1;
        1: begin
          r_redir = 1'b1;
          r_target[1:0] = 2'($urandom_range(1, 3));
        end
        2, 3, 4, 5: r_redir = 1'b1;
        6: r_word = EBREAK;
        7: begin
          r_status = 1'b1;
          r_redir  = 1'b1;
          r_target[0] = 1'b1;
        end
        default: ;
      endcase
      applyStimulus(r_word, r_gd, r_rd, r_status, r_redir, r_target);
      if (m_halted) begin
        doClear();
        doStart();
      end
    end

`ifdef VHM_SEQ_STEP_EN
    // Single-step: one instruction retires per step pulse
    $display("[TB] single step");
    step_en      = 1'b1;
    expect_pause = 1'b1;
    applyStimulus(32'h0000_0013, 0, 0, 1'b0, 1'b0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      repeat (2) begin
        @(negedge clk);
        checkOutput("pause_req", mem_req, 1'b0);
        checkOutput("pause_halted", halted, 1'b0);
        checkOutput("pause_retired", retired, m_retired);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      applyStimulus($urandom(), 0, 1, 1'b0, 1'b0, 64'h0);
    end
    step_en      = 1'b0;
    expect_pause = 1'b0;
    @(negedge clk);
    applyStimulus(32'h0000_0013, 1, 0, 1'b0, 1'b0, 64'h0);
`endif

    // Reset asserted while a fetch is outstanding
    $display("[TB] reset mid-fetch");
    applyStimulus(32'h0000_0013, 0, 0, 1'b0, 1'b0, 64'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_req", mem_req, 1'b0);
    checkOutput("midrst_pc", pc, RESET_PC);
    checkOutput("midrst_retired", retired, 64'd0);
    checkOutput("midrst_instr", instr, 32'd0);
    checkOutput("midrst_halted", halted, 1'b0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("postrst_req", mem_req, 1'b0);
    checkOutput("postrst_exec", exec_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
